xmit_priority_scheduler: RTL and testbench
==========================================

Name: xmit_priority_scheduler

Overview:
- Frame-level scheduler for the transmit path, in the clk_sys domain between the hi/lo priority frame queues and the PHY nibble serializer.
- Picks the next queue to serve, pops and checks that queue's 24-bit control word, and streams the frame's bytes to the serializer one byte per accepted cycle.
- Drains malformed frames with m_discard_en, enforces an inter-frame gap, and bounds low-priority starvation.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes.
- MAX_LEN, 1518, maximum legal frame length in bytes (must be < 4096).
- IFG_CYCLES, 12, idle clk_sys cycles inserted after every frame, sent or discarded (>= 1).
- MAX_HI_BURST, 4, consecutive hi frames allowed before a waiting lo frame must be served (>= 1).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hi_ctrl_valid  in  1  hi control FIFO non-empty
- hi_ctrl_in  in  24  hi control word: [23:12] length, [11:0] length copy
- hi_ctrl_rd  out  1  pop hi control FIFO
- hi_data_rd  out  1  pop one byte from hi data FIFO
- lo_ctrl_valid  in  1  lo control FIFO non-empty
- lo_ctrl_in  in  24  lo control word, same format
- lo_ctrl_rd  out  1  pop lo control FIFO
- lo_data_rd  out  1  pop one byte from lo data FIFO
- tx_ready  in  1  serializer can accept a byte this cycle
- tx_valid  out  1  byte presented to serializer (data mux follows tx_sel)
- tx_sel  out  1  1 = hi data FIFO feeds the serializer, 0 = lo
- tx_sof  out  1  first byte of frame (qualified by tx_valid)
- tx_eof  out  1  last byte of frame (qualified by tx_valid)
- m_discard_en  out  1  high while a rejected frame is being drained
- busy  out  1  state != IDLE

Behaviour:
- Data FIFOs are store-and-forward: a frame's bytes are fully present whenever its control word is valid.
- Reset: every output 0; state=IDLE; byte_cnt=0; hi_burst_cnt=0; ifg_cnt=0. Reset mid-frame aborts the frame immediately, with no eof and no further pops.
- States: IDLE, POP, CHECK, SEND, DRAIN, GAP.
- IDLE, arbitration:
  - choose lo if lo_ctrl_valid && (!hi_ctrl_valid || hi_burst_cnt==MAX_HI_BURST);
  - else choose hi if hi_ctrl_valid;
  - on a choice, latch sel and go to POP; otherwise stay in IDLE.
- POP: assert the selected *_ctrl_rd for exactly 1 cycle and latch the control word that cycle; go to CHECK.
- hi_burst_cnt: increments (saturating at MAX_HI_BURST) on each hi pop; clears to 0 on each lo pop.
- CHECK (1 cycle): len=ctrl[23:12].
  - If len==ctrl[11:0] && MIN_LEN<=len<=MAX_LEN: byte_cnt=len, go to SEND.
  - Otherwise: byte_cnt=ctrl[23:12], go to DRAIN. If that length is 0, go directly to GAP.
- SEND:
  - tx_sel=sel throughout.
  - tx_valid is high every SEND cycle. A byte transfers when tx_valid && tx_ready. On each transfer, pulse the selected *_data_rd in the same cycle and decrement byte_cnt.
  - tx_sof is high on the first byte until it transfers.
  - tx_eof is high while byte_cnt==1.
  - After the eof transfer, go to GAP.
  - If tx_ready is low, hold all outputs stable and pop nothing.
- DRAIN:
  - m_discard_en=1 and the selected *_data_rd=1 every cycle, regardless of tx_ready; tx_valid=0.
  - Decrement byte_cnt each cycle; after the pop with byte_cnt==1, go to GAP.
  - Does not touch the other queue.
- GAP: hold IFG_CYCLES cycles with all strobes 0, then go to IDLE. Arbitration happens only in IDLE, so the frame-to-frame ctrl_rd spacing is >= IFG_CYCLES+3 cycles.
- Simultaneous arrival of both ctrl_valid in IDLE: hi wins unless the burst limit is reached.
- hi_ctrl_valid and lo_ctrl_valid dropping while not in IDLE are ignored.
- Never asserts hi_* and lo_* strobes in the same cycle. Never asserts *_ctrl_rd unless the matching valid is high.

Test Plan:
- Single lo frame with ctrl=24'h200200, tx_ready=1:
  - lo_ctrl_rd pulses 1 cycle; 512 tx_valid cycles with tx_sel=0;
  - tx_sof on byte 1, tx_eof on byte 512; 512 lo_data_rd pulses;
  - then 12 idle cycles before busy drops.
- Both queues always valid, all frames 64 bytes (24'h040040), MAX_HI_BURST=4: grant order hi,hi,hi,hi,lo,hi,hi,hi,hi,lo…
- Backpressure: 64-byte hi frame with tx_ready toggling 1,0: exactly 64 transfers over 128 cycles; tx_sof, tx_eof and hi_data_rd occur only on ready cycles.
- Reject cases:
  - ctrl=24'h200100 (mismatch): 512 cycles of m_discard_en with lo_data_rd=1 and tx_valid=0, then GAP.
  - ctrl=24'h020020 (32 bytes < MIN_LEN): same behaviour for 32 cycles.
- Zero-length word 24'h000000 with valid high: 1 ctrl pop, no data pops, GAP, next frame served normally.
- Assert reset at byte 100 of a 512-byte frame: the next cycle all outputs are 0, state IDLE, hi_burst_cnt=0; a subsequent frame is scheduled cleanly.

Source files
------------

// File: rtl/xmit_priority_scheduler_if.sv
// Queue-side and serializer-side handshake bundle for the transmit frame scheduler.
// master = scheduler side, slave = queues/serializer side.
interface xmit_priority_scheduler_if;
    logic        hi_ctrl_valid;
    logic [23:0] hi_ctrl_in;
    logic        hi_ctrl_rd;
    logic        hi_data_rd;
    logic        lo_ctrl_valid;
    logic [23:0] lo_ctrl_in;
    logic        lo_ctrl_rd;
    logic        lo_data_rd;
    logic        tx_ready;
    logic        tx_valid;
    logic        tx_sel;
    logic        tx_sof;
    logic        tx_eof;

    modport master (
        input  hi_ctrl_valid, hi_ctrl_in, lo_ctrl_valid, lo_ctrl_in, tx_ready,
        output hi_ctrl_rd, hi_data_rd, lo_ctrl_rd, lo_data_rd,
        output tx_valid, tx_sel, tx_sof, tx_eof
    );

    modport slave (
        output hi_ctrl_valid, hi_ctrl_in, lo_ctrl_valid, lo_ctrl_in, tx_ready,
        input  hi_ctrl_rd, hi_data_rd, lo_ctrl_rd, lo_data_rd,
        input  tx_valid, tx_sel, tx_sof, tx_eof
    );
endinterface

// File: rtl/xmit_priority_scheduler.sv
// Hi/lo priority frame scheduler: arbitrates, validates the control word, streams or drains
// the frame bytes, then holds an inter-frame gap before the next arbitration.
module xmit_priority_scheduler #(
    parameter int MIN_LEN      = 64,
    parameter int MAX_LEN      = 1518,
    parameter int IFG_CYCLES   = 12,
    parameter int MAX_HI_BURST = 4
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    xmit_priority_scheduler_if.master  bus,
    output logic                       m_discard_en,
    output logic                       busy
);
    localparam int BW = $clog2(MAX_HI_BURST + 1);
    localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, POP, CHECK, SEND, DRAIN, GAP} state_t;

    state_t          state_reg, state_next;
    logic            sel_reg, sel_next;
    logic [23:0]     ctrl_reg, ctrl_next;
    logic [11:0]     byte_cnt_reg, byte_cnt_next;
    logic            first_reg, first_next;
    logic [IW-1:0]   ifg_cnt_reg, ifg_cnt_next;
    logic [BW-1:0]   hi_burst_cnt_reg, hi_burst_cnt_next;

    logic [11:0] len;
    logic        len_ok;
    logic        burst_full;
    logic        xfer;

    assign len        = ctrl_reg[23:12];
    assign len_ok     = (len == ctrl_reg[11:0]) && (len >= 12'(MIN_LEN)) && (len <= 12'(MAX_LEN));
    assign burst_full = (hi_burst_cnt_reg == BW'(MAX_HI_BURST));
    assign xfer       = (state_reg == SEND) && bus.tx_ready;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg        <= IDLE;
            sel_reg          <= 1'b0;
            ctrl_reg         <= '0;
            byte_cnt_reg     <= '0;
            first_reg        <= 1'b0;
            ifg_cnt_reg      <= '0;
            hi_burst_cnt_reg <= '0;
        end else begin
            state_reg        <= state_next;
            sel_reg          <= sel_next;
            ctrl_reg         <= ctrl_next;
            byte_cnt_reg     <= byte_cnt_next;
            first_reg        <= first_next;
            ifg_cnt_reg      <= ifg_cnt_next;
            hi_burst_cnt_reg <= hi_burst_cnt_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        sel_next          = sel_reg;
        ctrl_next         = ctrl_reg;
        byte_cnt_next     = byte_cnt_reg;
        first_next        = first_reg;
        ifg_cnt_next      = ifg_cnt_reg;
        hi_burst_cnt_next = hi_burst_cnt_reg;
        case (state_reg)
            IDLE: begin
                // lo only wins when hi is absent or hi has used up its burst allowance
                if (bus.lo_ctrl_valid && (!bus.hi_ctrl_valid || burst_full)) begin
                    sel_next   = 1'b0;
                    state_next = POP;
                end else if (bus.hi_ctrl_valid) begin
                    sel_next   = 1'b1;
                    state_next = POP;
                end
            end
            POP: begin
                ctrl_next = sel_reg ? bus.hi_ctrl_in : bus.lo_ctrl_in;
                if (sel_reg) begin
                    if (!burst_full) hi_burst_cnt_next = hi_burst_cnt_reg + 1'b1;
                end else begin
                    hi_burst_cnt_next = '0;
                end
                state_next = CHECK;
            end
            CHECK: begin
                byte_cnt_next = len;
                first_next    = 1'b1;
                ifg_cnt_next  = '0;
                if (len_ok)         state_next = SEND;
                else if (len == '0) state_next = GAP;
                else                state_next = DRAIN;
            end
            SEND: begin
                if (bus.tx_ready) begin
                    byte_cnt_next = byte_cnt_reg - 1'b1;
                    first_next    = 1'b0;
                    if (byte_cnt_reg == 12'd1) state_next = GAP;
                end
            end
            DRAIN: begin
                byte_cnt_next = byte_cnt_reg - 1'b1;
                if (byte_cnt_reg == 12'd1) state_next = GAP;
            end
            GAP: begin
                if (ifg_cnt_reg == IW'(IFG_CYCLES - 1)) begin
                    ifg_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    ifg_cnt_next = ifg_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Index 1 = hi queue, index 0 = lo queue; strobes only ever go to the latched selection.
    logic [1:0] ctrl_rd_vec;
    logic [1:0] data_rd_vec;
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_queue
            assign ctrl_rd_vec[gi] = (state_reg == POP) && (sel_reg == (gi == 1));
            assign data_rd_vec[gi] = (xfer || (state_reg == DRAIN)) && (sel_reg == (gi == 1));
        end
    endgenerate

    assign bus.hi_ctrl_rd = ctrl_rd_vec[1];
    assign bus.lo_ctrl_rd = ctrl_rd_vec[0];
    assign bus.hi_data_rd = data_rd_vec[1];
    assign bus.lo_data_rd = data_rd_vec[0];
    assign bus.tx_valid   = (state_reg == SEND);
    assign bus.tx_sel     = (state_reg == SEND) && sel_reg;
    assign bus.tx_sof     = (state_reg == SEND) && first_reg;
    assign bus.tx_eof     = (state_reg == SEND) && (byte_cnt_reg == 12'd1);
    assign m_discard_en   = (state_reg == DRAIN);
    assign busy           = (state_reg != IDLE);
endmodule

// File: tb/tb_xmit_priority_scheduler.sv
// Directed bench for xmit_priority_scheduler: queue model drives control words, a per-cycle
// monitor accumulates strobe statistics that each scenario compares against hand values.
module tb_xmit_priority_scheduler;
    logic clk_sys = 1'b0;
    logic reset;
    logic m_discard_en;
    logic busy;

    always #5 clk_sys = ~clk_sys;

    xmit_priority_scheduler_if bus_if();

    xmit_priority_scheduler #(
        .MIN_LEN(64), .MAX_LEN(1518), .IFG_CYCLES(12), .MAX_HI_BURST(4)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .bus          (bus_if),
        .m_discard_en (m_discard_en),
        .busy         (busy)
    );

    int checks = 0;
    int failures = 0;

    logic [23:0] hi_q[$];
    logic [23:0] lo_q[$];
    int          ready_mode = 0;   // 0: always ready, 1: toggle, 2: never ready
    int          exp_sel = 0;

    int hi_cpop, lo_cpop, hi_dpop, lo_dpop, xfers, valid_cycles;
    int sof_cnt, eof_cnt, eof_idx, frame_idx, first_sof, disc, disc_bad, stray, sel_wrong;
    int tail, gap_seen, last_cpop, last_spacing, cyc;
    int both_bad = 0, bad_rd = 0;
    logic [31:0] grant_log;
    logic [9:0]  last_outs;
    logic        busy_s, busy_prev;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic update_inputs();
        bus_if.hi_ctrl_valid = (hi_q.size() > 0);
        bus_if.hi_ctrl_in    = (hi_q.size() > 0) ? hi_q[0] : 24'h0;
        bus_if.lo_ctrl_valid = (lo_q.size() > 0);
        bus_if.lo_ctrl_in    = (lo_q.size() > 0) ? lo_q[0] : 24'h0;
    endtask

    task automatic clear_stats();
        hi_cpop = 0; lo_cpop = 0; hi_dpop = 0; lo_dpop = 0; xfers = 0; valid_cycles = 0;
        sof_cnt = 0; eof_cnt = 0; eof_idx = 0; frame_idx = 0; first_sof = -1;
        disc = 0; disc_bad = 0; stray = 0; sel_wrong = 0;
        tail = 0; gap_seen = -1; last_cpop = -1; last_spacing = -1; grant_log = '0;
    endtask

    // Sample one cycle on the falling edge, then apply queue pops and tx_ready after the rising edge.
    task automatic tick();
        logic xfer, dpop, pend_hi, pend_lo;
        @(negedge clk_sys);
        last_outs = {bus_if.hi_ctrl_rd, bus_if.lo_ctrl_rd, bus_if.hi_data_rd, bus_if.lo_data_rd,
                     bus_if.tx_valid, bus_if.tx_sel, bus_if.tx_sof, bus_if.tx_eof, m_discard_en, busy};
        busy_s  = (busy === 1'b1);
        pend_hi = (bus_if.hi_ctrl_rd === 1'b1);
        pend_lo = (bus_if.lo_ctrl_rd === 1'b1);
        xfer    = (bus_if.tx_valid === 1'b1) && (bus_if.tx_ready === 1'b1);
        dpop    = (bus_if.hi_data_rd === 1'b1) || (bus_if.lo_data_rd === 1'b1);
        if (pend_hi) begin
            hi_cpop++; grant_log = {grant_log[30:0], 1'b1};
            if (bus_if.hi_ctrl_valid !== 1'b1) bad_rd++;
        end
        if (pend_lo) begin
            lo_cpop++; grant_log = {grant_log[30:0], 1'b0};
            if (bus_if.lo_ctrl_valid !== 1'b1) bad_rd++;
        end
        if (pend_hi || pend_lo) begin
            if (last_cpop >= 0) last_spacing = cyc - last_cpop;
            last_cpop = cyc;
        end
        if ((bus_if.hi_ctrl_rd === 1'b1 || bus_if.hi_data_rd === 1'b1) &&
            (bus_if.lo_ctrl_rd === 1'b1 || bus_if.lo_data_rd === 1'b1)) both_bad++;
        if (bus_if.hi_data_rd === 1'b1) hi_dpop++;
        if (bus_if.lo_data_rd === 1'b1) lo_dpop++;
        if (dpop != (xfer || (m_discard_en === 1'b1))) stray++;
        if (bus_if.tx_valid === 1'b1) begin
            valid_cycles++;
            if (int'(bus_if.tx_sel) != exp_sel) sel_wrong++;
        end
        if (xfer) begin
            xfers++;
            if (first_sof < 0) first_sof = int'(bus_if.tx_sof);
            frame_idx = (bus_if.tx_sof === 1'b1) ? 1 : frame_idx + 1;
            if (bus_if.tx_sof === 1'b1) sof_cnt++;
            if (bus_if.tx_eof === 1'b1) begin eof_cnt++; eof_idx = frame_idx; end
        end
        if (m_discard_en === 1'b1) begin
            disc++;
            if (bus_if.tx_valid !== 1'b0) disc_bad++;
        end
        if (dpop || pend_hi || pend_lo) tail = 0;
        else if (busy_s) tail++;
        if (!busy_s && busy_prev) gap_seen = tail;
        busy_prev = busy_s;
        @(posedge clk_sys);
        #1;
        if (pend_hi && hi_q.size() > 0) hi_q.delete(0);
        if (pend_lo && lo_q.size() > 0) lo_q.delete(0);
        update_inputs();
        case (ready_mode)
            1:       bus_if.tx_ready = ~bus_if.tx_ready;
            2:       bus_if.tx_ready = 1'b0;
            default: bus_if.tx_ready = 1'b1;
        endcase
        cyc++;
    endtask

    task automatic run_until_idle(input string tag, input int limit);
        int done;
        done = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (hi_q.size() == 0 && lo_q.size() == 0 && !busy_s) begin
                done = 1;
                break;
            end
        end
        check_eq({tag, "_done"}, done, 1);
    endtask

    initial begin
        int d1, found;
        cyc = 0; busy_prev = 1'b0;
        reset = 1'b1;
        bus_if.tx_ready = 1'b1;
        update_inputs();
        clear_stats();
        repeat (3) tick();
        check_eq("reset_outputs", int'(last_outs), 0);
        reset = 1'b0;
        tick();
        clear_stats();

        // Single 512-byte lo frame, always ready
        exp_sel = 0; ready_mode = 0;
        lo_q.push_back(24'h200200); update_inputs();
        run_until_idle("lo512", 1000);
        check_eq("lo512_ctrl_pops", lo_cpop, 1);
        check_eq("lo512_hi_pops", hi_cpop, 0);
        check_eq("lo512_xfers", xfers, 512);
        check_eq("lo512_valid_cycles", valid_cycles, 512);
        check_eq("lo512_data_pops", lo_dpop, 512);
        check_eq("lo512_first_sof", first_sof, 1);
        check_eq("lo512_sof_cnt", sof_cnt, 1);
        check_eq("lo512_eof_idx", eof_idx, 512);
        check_eq("lo512_sel", sel_wrong, 0);
        check_eq("lo512_gap", gap_seen, 12);
        check_eq("lo512_stray", stray, 0);

        // Both queues loaded: burst limit forces lo every fifth grant
        clear_stats(); exp_sel = -1;
        for (int i = 0; i < 8; i++) hi_q.push_back(24'h040040);
        for (int i = 0; i < 2; i++) lo_q.push_back(24'h040040);
        update_inputs();
        run_until_idle("burst", 2000);
        check_eq("burst_order", int'(grant_log[9:0]), 'b1111011110);
        check_eq("burst_xfers", xfers, 640);
        check_eq("burst_eofs", eof_cnt, 10);
        check_eq("burst_hi_dpop", hi_dpop, 512);

        // Backpressure: ready toggles, first SEND cycle is a ready cycle
        clear_stats(); exp_sel = 1; ready_mode = 1;
        bus_if.tx_ready = 1'b0;
        hi_q.push_back(24'h040040); update_inputs();
        run_until_idle("bp", 1000);
        check_eq("bp_xfers", xfers, 64);
        check_eq("bp_valid_cycles", valid_cycles, 127);
        check_eq("bp_hi_dpop", hi_dpop, 64);
        check_eq("bp_stray", stray, 0);
        check_eq("bp_eof_idx", eof_idx, 64);
        check_eq("bp_sel", sel_wrong, 0);

        // Length mismatch on lo, serializer never ready: drain must proceed anyway
        clear_stats(); exp_sel = 0; ready_mode = 2;
        lo_q.push_back(24'h200100); update_inputs();
        run_until_idle("mism", 1000);
        check_eq("mism_discard", disc, 512);
        check_eq("mism_lo_dpop", lo_dpop, 512);
        check_eq("mism_hi_dpop", hi_dpop, 0);
        check_eq("mism_valid", valid_cycles, 0);
        check_eq("mism_disc_bad", disc_bad, 0);
        check_eq("mism_gap", gap_seen, 12);

        // Runt frame on hi
        clear_stats(); exp_sel = 1; ready_mode = 0;
        hi_q.push_back(24'h020020); update_inputs();
        run_until_idle("runt", 500);
        check_eq("runt_discard", disc, 32);
        check_eq("runt_hi_dpop", hi_dpop, 32);
        check_eq("runt_xfers", xfers, 0);

        // Zero-length word then a normal frame
        clear_stats(); exp_sel = 0;
        lo_q.push_back(24'h000000); lo_q.push_back(24'h040040); update_inputs();
        run_until_idle("zero", 500);
        check_eq("zero_ctrl_pops", lo_cpop, 2);
        check_eq("zero_spacing", last_spacing, 15);
        check_eq("zero_discard", disc, 0);
        check_eq("zero_xfers", xfers, 64);
        check_eq("zero_lo_dpop", lo_dpop, 64);

        // Reset in the middle of a 512-byte hi frame
        clear_stats(); exp_sel = 1;
        hi_q.push_back(24'h200200); update_inputs();
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (xfers >= 100) begin found = 1; break; end
        end
        check_eq("rst_reach_100", found, 1);
        reset = 1'b1;
        tick();
        d1 = hi_dpop;
        tick();
        check_eq("rst_outputs", int'(last_outs), 0);
        check_eq("rst_no_pops", hi_dpop, d1);
        check_eq("rst_no_eof", eof_cnt, 0);
        reset = 1'b0;
        tick();

        // Burst counter cleared by reset: four hi grants before lo
        clear_stats(); exp_sel = -1;
        for (int i = 0; i < 4; i++) hi_q.push_back(24'h040040);
        lo_q.push_back(24'h040040); update_inputs();
        run_until_idle("post_rst", 1500);
        check_eq("post_rst_order", int'(grant_log[4:0]), 'b11110);
        check_eq("post_rst_xfers", xfers, 320);

        check_eq("never_both_queues", both_bad, 0);
        check_eq("never_rd_without_valid", bad_rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
